// File: rtl/move_ball.sv
`default_nettype none
// move_ball: Breakout ball motion (launch from bar, wall/bar reflection, miss). Rev 1.0
// Optional macro SPEEDUP_EN: each bar hit raises the step by one, saturating at MAX_STEP.
module move_ball #(
  parameter int H_BAR    = 8,
  parameter int W_BAR    = 64,
  parameter int R_BALL   = 4,
  parameter int STEP     = 2,
  parameter int TICK_DIV = 500000,
  parameter int MAX_STEP = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] bar_x,
  input  logic [9:0] bar_y,
  input  logic       launch,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       bar_hit,
  output logic       miss,
  output logic [1:0] estado
);

  localparam int CW     = $clog2(TICK_DIV);
  localparam int STEP_W = $clog2(((MAX_STEP > STEP) ? MAX_STEP : STEP) + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, MISS = 2'd2} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     tick_cnt, cnt_n;
  logic              tick;
  logic [9:0]        x_n, y_n;
  logic              dir_x, dir_x_n;   // 1 = right
  logic              dir_y, dir_y_n;   // 1 = up
  logic              hit_n;
  logic              bar_ok;
  logic [10:0]       bx, by, bxb, byb, s;
  logic [STEP_W-1:0] step;

`ifdef SPEEDUP_EN
  always_ff @(posedge clock) begin
    if (reset || state == MISS)
      step <= STEP_W'(STEP);
    else if (hit_n && step < STEP_W'(MAX_STEP))
      step <= step + 1'b1;
  end
`else
  assign step = STEP_W'(STEP);
`endif

  assign bx   = {1'b0, ball_x};
  assign by   = {1'b0, ball_y};
  assign bxb  = {1'b0, bar_x};
  assign byb  = {1'b0, bar_y};
  assign s    = 11'(step);
  assign tick = (tick_cnt == CW'(TICK_DIV - 1));

  // Bar window rearranged so no term subtracts from a bar coordinate.
  assign bar_ok = (by + 11'(R_BALL + H_BAR) <= byb) &&
                  (by + s + 11'(R_BALL + H_BAR) >= byb) &&
                  (bx + 11'(R_BALL + W_BAR) >= bxb) &&
                  (bx <= bxb + 11'(W_BAR + R_BALL));

  always_comb begin
    state_n = state;
    x_n     = ball_x;
    y_n     = ball_y;
    dir_x_n = dir_x;
    dir_y_n = dir_y;
    hit_n   = 1'b0;
    cnt_n   = tick ? '0 : tick_cnt + 1'b1;
    case (state)
      IDLE: begin
        x_n = bar_x;
        y_n = 10'(byb - 11'(H_BAR + R_BALL));
        if (launch) begin
          state_n = MOVE;
          dir_x_n = 1'b1;
          dir_y_n = 1'b1;
          cnt_n   = '0;
        end
      end
      MOVE: if (tick) begin
        if (dir_x) begin
          if (bx + s > 11'(639 - R_BALL)) begin
            x_n = 10'(639 - R_BALL); dir_x_n = 1'b0;
          end else x_n = 10'(bx + s);
        end else begin
          if (bx < 11'(R_BALL) + s) begin
            x_n = 10'(R_BALL); dir_x_n = 1'b1;
          end else x_n = 10'(bx - s);
        end
        if (dir_y) begin
          if (by < 11'(R_BALL) + s) begin
            y_n = 10'(R_BALL); dir_y_n = 1'b0;
          end else y_n = 10'(by - s);
        end else if (bar_ok) begin
          // Bar reflection also decides horizontal direction from the pre-step x.
          y_n     = 10'(byb - 11'(H_BAR + R_BALL));
          dir_y_n = 1'b1;
          dir_x_n = (bx >= bxb);
          hit_n   = 1'b1;
        end else if (by + s > 11'(479 - R_BALL)) begin
          y_n     = 10'(479 - R_BALL);
          state_n = MISS;
        end else y_n = 10'(by + s);
      end
      MISS:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      ball_x   <= 10'd320;
      ball_y   <= 10'(464 - H_BAR - R_BALL);
      dir_x    <= 1'b1;
      dir_y    <= 1'b1;
      tick_cnt <= '0;
      bar_hit  <= 1'b0;
    end else begin
      state    <= state_n;
      ball_x   <= x_n;
      ball_y   <= y_n;
      dir_x    <= dir_x_n;
      dir_y    <= dir_y_n;
      tick_cnt <= cnt_n;
      bar_hit  <= hit_n;
    end
  end

  assign miss   = (state == MISS);
  assign estado = state;

endmodule
`default_nettype wire
